// File: rtl/ai_qos_arbiter.sv
// ai_qos_arbiter: credit-weighted round-robin N-to-1 packet arbiter feeding one output register.
// Latency: 1 cycle from grant (req_valid & req_ready) to out_valid; one packet per cycle while out_ready=1.
// Backpressure: grants only when the output register is empty or draining; optional AI_QOS_ARB_STATS_EN adds grant counters.
module ai_qos_arbiter #(
  parameter int N_REQ     = 4,
  parameter int PKT_WIDTH = 64,
  parameter int WEIGHT_W  = 4,
  localparam int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ*PKT_WIDTH-1:0] req_pkt,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  output logic [PKT_WIDTH-1:0]       out_pkt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IDX_W-1:0]           grant_id,
`ifdef AI_QOS_ARB_STATS_EN
  input  logic [IDX_W-1:0]           stat_idx,
  output logic [31:0]                stat_count,
  input  logic                       stat_clr,
`endif
  input  logic                       cfg_we,
  input  logic [IDX_W-1:0]           cfg_idx,
  input  logic [WEIGHT_W-1:0]        cfg_weight
);

  // Architectural state
  logic [PKT_WIDTH-1:0] out_pkt_q, out_pkt_d;
  logic                 out_valid_q, out_valid_d;
  logic [IDX_W-1:0]     grant_id_q, grant_id_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]  weight_q [N_REQ];
  logic [WEIGHT_W-1:0]  weight_d [N_REQ];
  logic [WEIGHT_W-1:0]  credit_q [N_REQ];
  logic [WEIGHT_W-1:0]  credit_d [N_REQ];

  // Decision signals
  logic             load;
  logic [N_REQ-1:0] base_elig;
  logic [N_REQ-1:0] cred_elig;
  logic [N_REQ-1:0] use_elig;
  logic             reload;
  logic             gnt_vld;
  logic [IDX_W-1:0] gnt_idx;
  logic [N_REQ-1:0] gnt_oh;
  logic             cfg_hit;

  // Eligibility: a zero weight masks a requester; when every weighted requester is out of
  // credit, the scan uses weights in place of credits (the reload case).
  always_comb begin
    load = !out_valid_q || out_ready;
    for (int i = 0; i < N_REQ; i++) begin
      base_elig[i] = req_valid[i] && (weight_q[i] != '0);
      cred_elig[i] = base_elig[i] && (credit_q[i] != '0);
    end
    reload   = load && !(|cred_elig) && (|base_elig);
    use_elig = reload ? base_elig : cred_elig;
  end

  // Round-robin pick: first eligible index after the last grantee, wrapping modulo N_REQ.
  always_comb begin
    int               p;
    logic [IDX_W-1:0] pidx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    p       = 0;
    pidx    = '0;
    if (load && !rst) begin
      for (int k = 1; k <= N_REQ; k++) begin
        p = int'(ptr_q) + k;
        if (p >= N_REQ) begin
          p = p - N_REQ;
        end
        pidx = IDX_W'(p);
        if (!gnt_vld && use_elig[pidx]) begin
          gnt_vld = 1'b1;
          gnt_idx = pidx;
        end
      end
    end
    if (gnt_vld) begin
      gnt_oh[gnt_idx] = 1'b1;
    end
  end

  assign req_ready = gnt_oh;
  assign out_pkt   = out_pkt_q;
  assign out_valid = out_valid_q;
  assign grant_id  = grant_id_q;

  // Next state: output register load/drain, pointer advance, credit consume/reload and weight writes.
  always_comb begin
    logic [WEIGHT_W-1:0] cred_tmp;
    logic                granted;
    logic                hit_i;
    out_valid_d = out_valid_q;
    out_pkt_d   = out_pkt_q;
    grant_id_d  = grant_id_q;
    ptr_d       = ptr_q;
    cred_tmp    = '0;
    granted     = 1'b0;
    hit_i       = 1'b0;
    cfg_hit     = cfg_we && (int'(cfg_idx) < N_REQ);

    if (gnt_vld) begin
      out_valid_d = 1'b1;
      grant_id_d  = gnt_idx;
      ptr_d       = gnt_idx;
    end else if (load) begin
      // Drained with nothing to replace it: packet and id are left as they were.
      out_valid_d = 1'b0;
    end

    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_oh[i]) begin
        out_pkt_d = req_pkt[i*PKT_WIDTH +: PKT_WIDTH];
      end
    end

    for (int i = 0; i < N_REQ; i++) begin
      granted     = gnt_vld && (gnt_idx == IDX_W'(i));
      hit_i       = cfg_hit && (cfg_idx == IDX_W'(i));
      weight_d[i] = weight_q[i];
      cred_tmp    = reload ? weight_q[i] : credit_q[i];
      if (granted && (cred_tmp != '0)) begin
        cred_tmp = cred_tmp - 1'b1;
      end
      if (hit_i) begin
        weight_d[i] = cfg_weight;
        if (reload) begin
          // A reload in the same cycle refills this slot from the new weight.
          cred_tmp = (granted && (cfg_weight != '0)) ? (cfg_weight - 1'b1) : cfg_weight;
        end else if (cfg_weight < cred_tmp) begin
          cred_tmp = cfg_weight;
        end
      end
      credit_d[i] = cred_tmp;
    end
  end

  // State register; reset discards any held word and starts the scan at requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_pkt_q   <= '0;
      grant_id_q  <= '0;
      ptr_q       <= IDX_W'(N_REQ - 1);
      for (int i = 0; i < N_REQ; i++) begin
        weight_q[i] <= WEIGHT_W'(1);
        credit_q[i] <= WEIGHT_W'(1);
      end
    end else begin
      out_valid_q <= out_valid_d;
      out_pkt_q   <= out_pkt_d;
      grant_id_q  <= grant_id_d;
      ptr_q       <= ptr_d;
      for (int i = 0; i < N_REQ; i++) begin
        weight_q[i] <= weight_d[i];
        credit_q[i] <= credit_d[i];
      end
    end
  end

`ifdef AI_QOS_ARB_STATS_EN
  logic [31:0] stat_cnt_q [N_REQ];
  logic [31:0] stat_cnt_d [N_REQ];

  // Saturating per-requester grant counters; a clear beats a same-cycle increment.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      stat_cnt_d[i] = stat_cnt_q[i];
      if (stat_clr) begin
        stat_cnt_d[i] = '0;
      end else if (gnt_oh[i] && (stat_cnt_q[i] != 32'hFFFF_FFFF)) begin
        stat_cnt_d[i] = stat_cnt_q[i] + 32'd1;
      end
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (rst) begin
        stat_cnt_q[i] <= '0;
      end else begin
        stat_cnt_q[i] <= stat_cnt_d[i];
      end
    end
  end

  assign stat_count = (int'(stat_idx) < N_REQ) ? stat_cnt_q[stat_idx] : 32'd0;
`else
  // Counters compiled out: grant activity is observable only through req_ready / grant_id.
`endif

endmodule

// File: doc/ai_qos_arbiter.md
AI_QOS_ARBITER -- requirements
Module: ai_qos_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning number of requesters (2..16).
REQ-002 SHALL have parameter PKT_WIDTH, default 64, meaning packet word width.
REQ-003 SHALL have parameter WEIGHT_W, default 4, meaning weight and credit width.
REQ-004 SHALL use one clock; reset is synchronous and active-high. Ports: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-005 req_pkt  input  N_REQ*PKT_WIDTH  requester packets, requester i at bits [i*PKT_WIDTH +: PKT_WIDTH].
REQ-006 req_valid  input  N_REQ  per-requester valid.
REQ-007 req_ready  output  N_REQ  per-requester accept, one-hot or zero.
REQ-008 out_pkt  output  PKT_WIDTH  registered granted packet.
REQ-009 out_valid  output  1  out_pkt valid.
REQ-010 out_ready  input  1  downstream accept.
REQ-011 grant_id  output  $clog2(N_REQ)  source index of out_pkt.
REQ-012 cfg_we  input  1  weight write strobe.
REQ-013 cfg_idx  input  $clog2(N_REQ)  weight write index.
REQ-014 cfg_weight  input  WEIGHT_W  weight value; 0 masks the requester.

Function
REQ-015 SHALL hold one output register; load = !out_valid | out_ready.
REQ-016 Eligible(i) SHALL be req_valid[i] & weight[i]!=0 & credit[i]!=0.
REQ-017 When load, SHALL grant the first eligible index scanning ptr+1, ptr+2, … modulo N_REQ.
REQ-018 A grant to i SHALL assert req_ready[i] combinationally in that cycle; all other req_ready SHALL be 0.
REQ-019 On a grant to i, the next edge SHALL set out_pkt to req_pkt[i], out_valid=1, grant_id=i, ptr=i, and credit[i]=credit[i]-1.
REQ-020 If load and no eligible index exists but some req_valid[i]&weight[i]!=0 exists, credits SHALL be treated as reloaded to weights this cycle, and the grant SHALL use the reloaded values.
REQ-021 On a reload, the grantee's stored credit SHALL be weight-1.
REQ-022 On a reload, all other credits SHALL equal their weights.
REQ-023 If load and no grant occurs, the next edge SHALL clear out_valid; out_pkt and grant_id SHALL hold.
REQ-024 If !load, SHALL grant nothing, and out_pkt, out_valid and grant_id SHALL hold.
REQ-025 Latency SHALL be 1 cycle from accept to out_valid.
REQ-026 Throughput SHALL be one packet per cycle while out_ready=1.
REQ-027 cfg_we SHALL set weight[cfg_idx]=cfg_weight and credit[cfg_idx]=min(credit,cfg_weight) at the next edge.
REQ-028 A cfg write in the same cycle as a grant to the same index SHALL give credit=min(credit-1,cfg_weight); the grant SHALL use the pre-write weight.
REQ-029 A cfg write in the same cycle as a reload SHALL give that index credit=cfg_weight, or cfg_weight-1 if granted.
REQ-030 cfg_idx >= N_REQ SHALL be ignored.
REQ-031 Credit arithmetic SHALL never underflow; credit SHALL be <= weight at all times.

Reset
REQ-032 On rst, SHALL set out_valid=0, out_pkt=0, grant_id=0, all weight=1, all credit=1, ptr=N_REQ-1 (requester 0 first).
REQ-033 req_ready SHALL be 0 during rst.
REQ-034 rst mid-packet SHALL discard the held output word with no replay.

Configuration
REQ-035 Macro AI_QOS_ARB_STATS_EN SHALL compile in per-requester 32-bit grant counters, ports stat_idx input $clog2(N_REQ), stat_count output 32 (combinational read), and stat_clr input 1.
REQ-036 With AI_QOS_ARB_STATS_EN, counters SHALL increment per grant, saturate at 0xFFFFFFFF, and clear on rst or stat_clr; stat_clr SHALL win over a same-cycle increment.
REQ-037 Without AI_QOS_ARB_STATS_EN, stat ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-038 Weights 1,1,1,1, all valid, out_ready=1 -> grant_id sequence 0,1,2,3,0… and one out_valid per cycle.
REQ-039 Weights 3,1,0,0, req 0 and 1 valid continuously -> repeating grant pattern 0,1,0,0 (75%/25%), requester 2 never granted.
REQ-040 out_ready=0 for 5 cycles with valid output -> out_pkt/grant_id stable, req_ready=0; first cycle after out_ready=1 -> next grant in that same cycle.
REQ-041 Write weight[1]=0 while req 1 holds credit 2 -> credit[1]=0 next cycle, no further grants to 1; requester 0 alone -> 0 granted every cycle via reload.
REQ-042 Assert rst during streaming -> next cycle out_valid=0, first grant after reset goes to requester 0.
REQ-043 With AI_QOS_ARB_STATS_EN, 10 grants to requester 2 then stat_idx=2 -> stat_count=10; stat_clr -> 0.
